// File: rtl/riscv_mem_pkg.sv
// Shared RV32I load/store definitions: funct3 codes, LSU state type and
// the word-index width helper used by the data-memory LSU.
package riscv_mem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } lsu_state_t;

   function automatic int word_idx_w(input int depth_words);
      return $clog2(depth_words);
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the LSU: store byte enables and lane data,
// load extraction with RV32I sign/zero extension, and access fault detection.
module lsu_lane_align
   import riscv_mem_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_ext,
   output logic        fault
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;
   logic        misalign_s;
   logic        illegal_s;

   // pick the addressed byte and halfword out of the memory word
   always_comb begin
      byte_s = rword[{addr_lo, 3'b000} +: 8];
      half_s = rword[{addr_lo[1], 4'b0000} +: 16];
   end

   // misalignment and illegal-size detection; store codes share the load encodings
   always_comb begin
      misalign_s = 1'b0;
      illegal_s  = 1'b0;
      case (funct3)
         F3_LB:   illegal_s = 1'b0;
         F3_LH:   misalign_s = addr_lo[0];
         F3_LW:   misalign_s = (addr_lo != 2'b00);
         F3_LBU:  illegal_s = we;
         F3_LHU: begin
            illegal_s  = we;
            misalign_s = addr_lo[0];
         end
         default: illegal_s = 1'b1;
      endcase
      fault = misalign_s | illegal_s;
   end

   // store side: replicate data across lanes and enable only the addressed bytes
   always_comb begin
      byte_en    = 4'b0000;
      wdata_lane = wdata;
      if (we && !fault) begin
         case (funct3)
            F3_SB: begin
               byte_en    = 4'b0001 << addr_lo;
               wdata_lane = {4{wdata[7:0]}};
            end
            F3_SH: begin
               byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
               wdata_lane = {2{wdata[15:0]}};
            end
            F3_SW:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
         endcase
      end else begin
         byte_en = 4'b0000;
      end
   end

   // load side: extend the selected lane; stores and faults return zero
   always_comb begin
      rdata_ext = 32'h0000_0000;
      if (!we && !fault) begin
         case (funct3)
            F3_LB:   rdata_ext = {{24{byte_s[7]}}, byte_s};
            F3_LH:   rdata_ext = {{16{half_s[15]}}, half_s};
            F3_LW:   rdata_ext = rword;
            F3_LBU:  rdata_ext = {24'h00_0000, byte_s};
            F3_LHU:  rdata_ext = {16'h0000, half_s};
            default: rdata_ext = 32'h0000_0000;
         endcase
      end else begin
         rdata_ext = 32'h0000_0000;
      end
   end

endmodule

// File: rtl/dmem_lsu.sv
// Data memory with RV32I byte/halfword/word load-store, fault reporting and a
// fixed wait-state latency behind a valid/ready request and a one-cycle response.
module dmem_lsu
   import riscv_mem_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            rsp_valid,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_fault
);

   localparam int         IDX_W  = word_idx_w(DEPTH_WORDS);
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   if (XLEN != 32) begin : g_bad_xlen
      $error("dmem_lsu: XLEN must be 32");
   end
   if ((DEPTH_WORDS < 2) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
      $error("dmem_lsu: DEPTH_WORDS must be a power of two");
   end
   if ((LATENCY < 1) || (LATENCY > 15)) begin : g_bad_latency
      $error("dmem_lsu: LATENCY must be within 1..15");
   end

   lsu_state_t        state_r, state_s;
   logic [3:0]        cnt_r, cnt_s;
   logic              we_r;
   logic [2:0]        funct3_r;
   logic [IDX_W+1:0]  addr_r;
   logic [XLEN-1:0]   wdata_r;
   logic              cur_we_s;
   logic [2:0]        cur_funct3_s;
   logic [IDX_W+1:0]  cur_addr_s;
   logic [XLEN-1:0]   cur_wdata_s;
   logic [IDX_W-1:0]  cur_idx_s;
   logic [XLEN-1:0]   rword_s;
   logic [3:0]        byte_en_s;
   logic [XLEN-1:0]   wdata_lane_s;
   logic [XLEN-1:0]   rdata_ext_s;
   logic              fault_s;
   logic              accept_s;
   logic              enter_resp_s;
   logic              commit_s;
   logic              ready_s;
   logic              unused_addr_s;
   logic [XLEN-1:0]   mem_r [DEPTH_WORDS];

   assign unused_addr_s = ^req_addr[XLEN-1:IDX_W+2];

   // with LATENCY==1 the accepting edge is also the RESP edge, so use live inputs in IDLE
   always_comb begin
      if (state_r == IDLE) begin
         cur_we_s     = req_we;
         cur_funct3_s = req_funct3;
         cur_addr_s   = req_addr[IDX_W+1:0];
         cur_wdata_s  = req_wdata;
      end else begin
         cur_we_s     = we_r;
         cur_funct3_s = funct3_r;
         cur_addr_s   = addr_r;
         cur_wdata_s  = wdata_r;
      end
      cur_idx_s = cur_addr_s[IDX_W+1:2];
      rword_s   = mem_r[cur_idx_s];
   end

   lsu_lane_align u_align (
      .we         (cur_we_s),
      .funct3     (cur_funct3_s),
      .addr_lo    (cur_addr_s[1:0]),
      .wdata      (cur_wdata_s),
      .rword      (rword_s),
      .byte_en    (byte_en_s),
      .wdata_lane (wdata_lane_s),
      .rdata_ext  (rdata_ext_s),
      .fault      (fault_s)
   );

   // state register and wait counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end
   end

   // next-state logic
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (req_valid) begin
               if (LATENCY == 1) begin
                  state_s = RESP;
               end else begin
                  state_s = WAIT;
                  cnt_s   = LAT_M1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         WAIT: begin
            if (cnt_r <= 4'd1) begin
               state_s = RESP;
               cnt_s   = 4'd0;
            end else begin
               cnt_s = cnt_r - 4'd1;
            end
         end
         RESP:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // output / strobe decode
   always_comb begin
      accept_s     = (state_r == IDLE) && req_valid;
      enter_resp_s = (state_s == RESP) && (state_r != RESP);
      commit_s     = enter_resp_s && cur_we_s && !fault_s && !reset;
      ready_s      = (state_s == IDLE);
   end

   // capture the request on acceptance so req_* need not be held
   always_ff @(posedge clk) begin
      if (reset) begin
         we_r     <= 1'b0;
         funct3_r <= 3'b000;
         addr_r   <= '0;
         wdata_r  <= '0;
      end else if (accept_s) begin
         we_r     <= req_we;
         funct3_r <= req_funct3;
         addr_r   <= req_addr[IDX_W+1:0];
         wdata_r  <= req_wdata;
      end
   end

   // registered handshake and response outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_fault <= 1'b0;
      end else begin
         req_ready <= ready_s;
         rsp_valid <= enter_resp_s;
         if (enter_resp_s) begin
            rsp_rdata <= rdata_ext_s;
            rsp_fault <= fault_s;
         end
      end
   end

   // byte-lane store commit; contents survive reset
   always_ff @(posedge clk) begin
      if (commit_s) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en_s[b]) begin
               mem_r[cur_idx_s][b*8 +: 8] <= wdata_lane_s[b*8 +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized self-checking bench for dmem_lsu: one instance with LATENCY=1 and
// one with LATENCY=4, both checked against a byte-addressed reference model.
module tb_dmem_lsu;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset      [2];
   logic        req_valid  [2];
   logic        req_ready  [2];
   logic        req_we     [2];
   logic [2:0]  req_funct3 [2];
   logic [31:0] req_addr   [2];
   logic [31:0] req_wdata  [2];
   logic        rsp_valid  [2];
   logic [31:0] rsp_rdata  [2];
   logic        rsp_fault  [2];

   int          lat [2] = '{1, 4};
   logic [7:0]  mem_model [2][4096];
   int          n_tests = 0;
   int          n_fail  = 0;

   dmem_lsu #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(1)) u_lat1 (
      .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
      .rsp_fault(rsp_fault[0])
   );

   dmem_lsu #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(4)) u_lat4 (
      .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
      .rsp_fault(rsp_fault[1])
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // reference: byte-addressed memory of 4096 bytes, access size from funct3
   function automatic void model_op(input int d, input bit we, input bit [2:0] f3,
                                    input bit [31:0] a, input bit [31:0] wd,
                                    output bit [31:0] rd, output bit flt);
      bit        legal;
      int        sz;
      int        base;
      bit [63:0] v;
      legal = we ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      sz    = 1 << f3[1:0];
      base  = int'(a[11:0]);
      rd    = 32'd0;
      flt   = !legal || ((int'(a[1:0]) % sz) != 0);
      if (!flt) begin
         if (we) begin
            for (int i = 0; i < sz; i++) mem_model[d][base + i] = wd[8*i +: 8];
         end else begin
            v = 64'd0;
            for (int i = 0; i < sz; i++) v = v | (64'(mem_model[d][base + i]) << (8 * i));
            if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((64'd1 << (8 * sz)) - 64'd1);
            rd = v[31:0];
         end
      end
   endfunction

   task automatic do_op(input int d, input bit we, input bit [2:0] f3, input bit [31:0] a,
                        input bit [31:0] wd, input bit hold,
                        output bit [31:0] rd, output bit flt);
      int        e;
      bit [31:0] erd;
      bit        eflt;
      e = 0;
      while (req_ready[d] !== 1'b1 && e < 50) begin
         @(negedge clk);
         e++;
      end
      check_eq("ready_before_req", 32'(req_ready[d]), 32'd1);
      req_valid[d]  = 1'b1;
      req_we[d]     = we;
      req_funct3[d] = f3;
      req_addr[d]   = a;
      req_wdata[d]  = wd;
      @(posedge clk);
      #1;
      model_op(d, we, f3, a, wd, erd, eflt);
      if (hold) begin
         req_we[d]     = 1'b1;
         req_funct3[d] = 3'b010;
         req_addr[d]   = 32'($urandom_range(0, 15) * 4);
         req_wdata[d]  = $urandom;
      end else begin
         req_valid[d] = 1'b0;
      end
      e = 0;
      do begin
         @(negedge clk);
         e++;
         if (hold) check_eq("ready_low_busy", 32'(req_ready[d]), 32'd0);
      end while (rsp_valid[d] !== 1'b1 && e < lat[d] + 8);
      req_valid[d] = 1'b0;
      check_eq("latency", 32'(e), 32'(lat[d]));
      rd  = rsp_rdata[d];
      flt = rsp_fault[d];
      check_eq("rdata", rd, erd);
      check_eq("fault", 32'(flt), 32'(eflt));
      @(negedge clk);
      check_eq("rsp_one_cycle", 32'(rsp_valid[d]), 32'd0);
      check_eq("ready_after", 32'(req_ready[d]), 32'd1);
   endtask

   initial begin
      bit [31:0] rd;
      bit        flt;
      bit        seen;
      for (int d = 0; d < 2; d++) begin
         reset[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0;
         req_funct3[d] = 3'b000; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check_eq("reset_ready", 32'(req_ready[d]), 32'd1);
         check_eq("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
         check_eq("reset_rdata", rsp_rdata[d], 32'd0);
         check_eq("reset_fault", 32'(rsp_fault[d]), 32'd0);
         reset[d] = 1'b0;
      end
      @(negedge clk);

      // fill a 16-word window so every later load has known contents
      for (int d = 0; d < 2; d++)
         for (int w = 0; w < 16; w++) do_op(d, 1'b1, 3'b010, 32'(w * 4), $urandom, 1'b0, rd, flt);

      // LATENCY=1 directed cases
      do_op(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, rd, flt);
      check_eq("sw_ok_fault", 32'(flt), 32'd0);
      do_op(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, flt);
      check_eq("lw_deadbeef", rd, 32'hDEADBEEF);
      do_op(0, 1'b1, 3'b010, 32'h10, 32'h0, 1'b0, rd, flt);
      do_op(0, 1'b1, 3'b000, 32'h13, 32'h80, 1'b0, rd, flt);
      do_op(0, 1'b0, 3'b000, 32'h13, 32'h0, 1'b0, rd, flt);
      check_eq("lb_sext", rd, 32'hFFFFFF80);
      do_op(0, 1'b0, 3'b100, 32'h13, 32'h0, 1'b0, rd, flt);
      check_eq("lbu_zext", rd, 32'h00000080);
      do_op(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, flt);
      check_eq("lw_after_sb", rd, 32'h80000000);
      do_op(0, 1'b1, 3'b010, 32'h10, 32'h80010000, 1'b0, rd, flt);
      do_op(0, 1'b0, 3'b001, 32'h12, 32'h0, 1'b0, rd, flt);
      check_eq("lh_sext", rd, 32'hFFFF8001);
      do_op(0, 1'b0, 3'b101, 32'h12, 32'h0, 1'b0, rd, flt);
      check_eq("lhu_zext", rd, 32'h00008001);
      do_op(0, 1'b0, 3'b001, 32'h11, 32'h0, 1'b0, rd, flt);
      check_eq("lh_misalign_fault", 32'(flt), 32'd1);
      check_eq("lh_misalign_rdata", rd, 32'd0);
      do_op(0, 1'b1, 3'b010, 32'h06, 32'h12345678, 1'b0, rd, flt);
      check_eq("sw_misalign_fault", 32'(flt), 32'd1);
      do_op(0, 1'b0, 3'b010, 32'h04, 32'h0, 1'b0, rd, flt);
      do_op(0, 1'b0, 3'b010, 32'h08, 32'h0, 1'b0, rd, flt);

      // LATENCY=4: held req_valid during WAIT is ignored, upper address bits alias
      do_op(1, 1'b1, 3'b010, 32'h1010, 32'h13572468, 1'b1, rd, flt);
      do_op(1, 1'b0, 3'b010, 32'h0010, 32'h0, 1'b1, rd, flt);
      check_eq("alias_lw", rd, 32'h13572468);

      // LATENCY=4: reset two edges into a store abandons it
      do_op(1, 1'b1, 3'b010, 32'h20, 32'h0BADF00D, 1'b0, rd, flt);
      req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = 3'b010;
      req_addr[1] = 32'h20; req_wdata[1] = 32'hAAAA5555;
      @(posedge clk);
      #1 req_valid[1] = 1'b0;
      @(posedge clk);
      #1 reset[1] = 1'b1;
      @(posedge clk);
      #1 reset[1] = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rsp_valid[1] === 1'b1) seen = 1'b1;
      end
      check_eq("no_rsp_after_reset", 32'(seen), 32'd0);
      check_eq("ready_after_reset", 32'(req_ready[1]), 32'd1);
      do_op(1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, rd, flt);
      check_eq("store_abandoned", rd, 32'h0BADF00D);

      // randomized traffic over the initialised window with random alias bits
      for (int i = 0; i < 240; i++) begin
         int d;
         d = i % 2;
         do_op(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)), $urandom,
               (d == 1) && ($urandom_range(0, 3) == 0), rd, flt);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
